// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle RV32I sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM    = 2'b10,
    CAUSE_DMEM    = 2'b11
  } cause_t;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter: counts cycles spent waiting for an ack and flags
// the last cycle still allowed before the sequencer gives up.
module ctrl_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Clear while not waiting or once acked, otherwise count wait cycles.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  // Counter holds MEM_TIMEOUT-1 during the final permitted wait cycle.
  assign expired = (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB with memory
// handshakes, timeout/illegal halt and a retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic             dec_rd_en,
  input  logic             dec_ld_en,
  input  logic             dec_st_en,
  input  logic             dec_illegal,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             pc_we,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t cur;
  cause_t cause;
  logic   run;
  logic   ld_f, st_f, rd_f;
  logic   waiting, ack_now, timer_clr, timer_inc, expired;

  // run stays low for the first cycle after a reset edge so that every
  // output (imem_req included) reads 0 in that cycle.
  assign waiting   = run && ((cur == FETCH) || (cur == MEM));
  assign ack_now   = (cur == FETCH) ? imem_ack : dmem_ack;
  assign timer_clr = !waiting || ack_now;
  assign timer_inc = waiting && !ack_now;

  ctrl_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (expired)
  );

  // Strobes decoded from state and latched flags; ir_we and store pc_we
  // follow the ack within the same cycle.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    alu_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    pc_we    = 1'b0;
    halt     = 1'b0;
    case (cur)
      FETCH: begin
        imem_req = run;
        ir_we    = run && imem_ack;
      end
      EXEC: begin
        alu_en = 1'b1;
        pc_we  = !(ld_f || st_f || rd_f);
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = st_f;
        pc_we    = st_f && dmem_ack;
      end
      WB: begin
        rf_we  = 1'b1;
        wb_sel = ld_f;
        pc_we  = 1'b1;
      end
      HALT:    halt = 1'b1;
      default: ;
    endcase
  end

  assign state      = cur;
  assign halt_cause = cause;

  // Sequencer state, decode flag latches, halt cause and retired counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur     <= FETCH;
      cause   <= CAUSE_NONE;
      run     <= 1'b0;
      ld_f    <= 1'b0;
      st_f    <= 1'b0;
      rd_f    <= 1'b0;
      retired <= '0;
    end else begin
      run <= 1'b1;
      if (pc_we) begin
        retired <= retired + CNT_W'(1);
      end
      case (cur)
        FETCH: begin
          if (run) begin
            if (imem_ack) begin
              cur <= DECODE;
            end else if (expired) begin
              cur   <= HALT;
              cause <= CAUSE_IMEM;
            end
          end
        end
        DECODE: begin
          ld_f <= dec_ld_en;
          st_f <= dec_st_en;
          rd_f <= dec_rd_en;
          if (dec_illegal || (dec_ld_en && dec_st_en)) begin
            cur   <= HALT;
            cause <= CAUSE_ILLEGAL;
          end else begin
            cur <= EXEC;
          end
        end
        EXEC: begin
          if (ld_f || st_f) begin
            cur <= MEM;
          end else if (rd_f) begin
            cur <= WB;
          end else begin
            cur <= FETCH;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            cur <= ld_f ? WB : FETCH;
          end else if (expired) begin
            cur   <= HALT;
            cause <= CAUSE_DMEM;
          end
        end
        WB:      cur <= FETCH;
        HALT:    cur <= HALT;
        default: cur <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference trace with random
// decoder/ack noise in cycles where those inputs must be ignored.
module tb_multicycle_ctrl;

  localparam int unsigned TO   = 16;
  localparam int unsigned CW   = 4;
  localparam int unsigned HOLD = 100;

  localparam int unsigned K_ALU  = 0;
  localparam int unsigned K_NOP  = 1;
  localparam int unsigned K_LD   = 2;
  localparam int unsigned K_ST   = 3;
  localparam int unsigned K_ILL  = 4;
  localparam int unsigned K_LDST = 5;

  // {imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, wb_sel, pc_we, halt}
  localparam logic [8:0] O_IREQ  = 9'b100000000;
  localparam logic [8:0] O_IRWE  = 9'b010000000;
  localparam logic [8:0] O_ALU   = 9'b001000000;
  localparam logic [8:0] O_DREQ  = 9'b000100000;
  localparam logic [8:0] O_DWE   = 9'b000010000;
  localparam logic [8:0] O_RFWE  = 9'b000001000;
  localparam logic [8:0] O_WBSEL = 9'b000000100;
  localparam logic [8:0] O_PCWE  = 9'b000000010;
  localparam logic [8:0] O_HALT  = 9'b000000001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req, imem_ack = 1'b0, ir_we;
  logic          dec_rd_en = 1'b0, dec_ld_en = 1'b0, dec_st_en = 1'b0, dec_illegal = 1'b0;
  logic          alu_en, dmem_req, dmem_we, dmem_ack = 1'b0;
  logic          rf_we, wb_sel, pc_we, halt;
  logic [1:0]    halt_cause;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .ir_we       (ir_we),
    .dec_rd_en   (dec_rd_en),
    .dec_ld_en   (dec_ld_en),
    .dec_st_en   (dec_st_en),
    .dec_illegal (dec_illegal),
    .alu_en      (alu_en),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .pc_we       (pc_we),
    .halt        (halt),
    .halt_cause  (halt_cause),
    .state       (state),
    .retired     (retired)
  );

  typedef struct {
    logic        ia, da, ill, ld, st, rd;
    logic [8:0]  o;
    logic [2:0]  s;
    logic [1:0]  c;
    int unsigned ret;
  } cyc_t;

  cyc_t        tr[$];
  int unsigned mret;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [8:0] outs();
    return {imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, wb_sel, pc_we, halt};
  endfunction

  // One expected cycle; inputs default to noise that the DUT must ignore.
  function automatic cyc_t cy(input logic [2:0] s, input logic [8:0] o, input logic [1:0] c);
    cyc_t x;
    x.ia  = 1'($urandom);
    x.da  = 1'($urandom);
    x.ill = 1'($urandom);
    x.ld  = 1'($urandom);
    x.st  = 1'($urandom);
    x.rd  = 1'($urandom);
    x.s   = s;
    x.o   = o;
    x.c   = c;
    x.ret = 0;
    return x;
  endfunction

  // Retired count seen in a cycle = completed instructions before it.
  function automatic void push(input cyc_t x);
    cyc_t y;
    y     = x;
    y.ret = mret;
    tr.push_back(y);
    if ((x.o & O_PCWE) != 9'd0) mret++;
  endfunction

  function automatic void push_halt(input logic [1:0] c);
    for (int unsigned i = 0; i < HOLD; i++) push(cy(3'd7, O_HALT, c));
  endfunction

  // f/m = wait cycles before imem/dmem ack; f or m >= TO means no ack at all.
  function automatic void push_instr(input int unsigned kind, input int unsigned f,
                                     input int unsigned m);
    cyc_t x;
    logic ld, st;
    ld = (kind == K_LD);
    st = (kind == K_ST);
    for (int unsigned i = 0; i <= f && i < TO; i++) begin
      x    = cy(3'd0, O_IREQ | ((i == f) ? O_IRWE : 9'd0), 2'b00);
      x.ia = (i == f);
      push(x);
    end
    if (f >= TO) begin
      push_halt(2'b10);
      return;
    end
    x = cy(3'd1, 9'd0, 2'b00);
    case (kind)
      K_ALU:  begin x.ill = 0; x.ld = 0; x.st = 0; x.rd = 1; end
      K_NOP:  begin x.ill = 0; x.ld = 0; x.st = 0; x.rd = 0; end
      K_LD:   begin x.ill = 0; x.ld = 1; x.st = 0; end
      K_ST:   begin x.ill = 0; x.ld = 0; x.st = 1; end
      K_ILL:  x.ill = 1;
      default: begin x.ill = 0; x.ld = 1; x.st = 1; end
    endcase
    push(x);
    if (kind >= K_ILL) begin
      push_halt(2'b01);
      return;
    end
    push(cy(3'd2, O_ALU | ((kind == K_NOP) ? O_PCWE : 9'd0), 2'b00));
    if (kind == K_NOP) return;
    if (ld || st) begin
      for (int unsigned i = 0; i <= m && i < TO; i++) begin
        x = cy(3'd3, O_DREQ | (st ? O_DWE : 9'd0) | ((st && i == m) ? O_PCWE : 9'd0), 2'b00);
        x.da = (i == m);
        push(x);
      end
      if (m >= TO) begin
        push_halt(2'b11);
        return;
      end
      if (st) return;
    end
    push(cy(3'd4, O_RFWE | (ld ? O_WBSEL : 9'd0) | O_PCWE, 2'b00));
  endfunction

  task automatic play_n(input string tag, input int unsigned n);
    cyc_t        x;
    int unsigned k;
    logic [CW-1:0] er;
    k = 0;
    while (tr.size() > 0 && k < n) begin
      x = tr.pop_front();
      @(posedge clk);
      #1;
      imem_ack    = x.ia;
      dmem_ack    = x.da;
      dec_illegal = x.ill;
      dec_ld_en   = x.ld;
      dec_st_en   = x.st;
      dec_rd_en   = x.rd;
      @(negedge clk);
      checks++;
      if (outs() !== x.o || state !== x.s || halt_cause !== x.c) begin
        errors++;
        $display("FAIL %s cyc%0d outs/state/cause got=%b/%0d/%0d exp=%b/%0d/%0d",
                 tag, k, outs(), state, halt_cause, x.o, x.s, x.c);
      end
      er = CW'(x.ret);
      checks++;
      if (retired !== er) begin
        errors++;
        $display("FAIL %s cyc%0d retired got=%0d exp=%0d", tag, k, retired, er);
      end
      k++;
    end
  endtask

  task automatic play(input string tag);
    play_n(tag, 32'hffff_ffff);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    checks++;
    if (outs() !== 9'd0 || state !== 3'd0 || halt_cause !== 2'b00 || retired !== '0) begin
      errors++;
      $display("FAIL %s outs/state/cause/retired got=%b/%0d/%0d/%0d exp=0/0/0/0",
               tag, outs(), state, halt_cause, retired);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mret  = 0;
    tr.delete();
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset");
  endtask

  task automatic test_addi();
    do_reset();
    push_instr(K_ALU, 0, 0);
    push_instr(K_NOP, 0, 0);
    play("addi");
  endtask

  task automatic test_load_wait();
    push_instr(K_LD, 0, 3);
    push_instr(K_ALU, 2, 0);
    play("lw_wait");
  endtask

  task automatic test_store();
    push_instr(K_ST, 0, 0);
    push_instr(K_ST, 1, 2);
    play("sw");
  endtask

  task automatic test_illegal();
    push_instr(K_ILL, 1, 0);
    play("illegal");
    do_reset();
    push_instr(K_LDST, 0, 0);
    play("ld_and_st");
    do_reset();
  endtask

  task automatic test_timeout();
    push_instr(K_ALU, TO, 0);
    play("imem_timeout");
    do_reset();
    push_instr(K_ALU, TO - 1, 0);
    push_instr(K_LD, 0, TO - 1);
    play("ack_at_limit");
    push_instr(K_ST, 0, TO);
    play("dmem_timeout");
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    push_instr(K_LD, 0, 6);
    play_n("mid_mem_pre", 5);
    tr.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    dmem_ack = 1'b0;
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mret  = 0;
    check_idle("mid_mem_reset");
    push_instr(K_ALU, 1, 0);
    play("after_mid_reset");
  endtask

  task automatic test_back_to_back();
    int unsigned f, m;
    for (int unsigned n = 0; n < 60; n++) begin
      f = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
      m = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
      push_instr($urandom_range(K_ALU, K_ST), f, m);
    end
    play("random");
  endtask

  initial begin
    mret = 0;
    test_reset();
    test_addi();
    test_load_wait();
    test_store();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
